// File: rtl/dice_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : dice_scoreboard_if
// Description : Roll handshake and score/status bundle for dice_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
interface dice_scoreboard_if;
  logic       clear;
  logic       dice_valid;
  logic [2:0] dice_value;
  logic       dice_ready;
  logic [7:0] total;
  logic [4:0] roll_count;
  logic [2:0] last_value;
  logic       double_flag;
  logic       err_invalid;
  logic       game_won;
  logic       game_lost;

  modport master (
    output clear, dice_valid, dice_value,
    input  dice_ready, total, roll_count, last_value,
    input  double_flag, err_invalid, game_won, game_lost
  );

  modport slave (
    input  clear, dice_valid, dice_value,
    output dice_ready, total, roll_count, last_value,
    output double_flag, err_invalid, game_won, game_lost
  );
endinterface
`default_nettype wire

// File: rtl/dice_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : dice_scoreboard
// Description : Dice game scorer with win/lose FSM and double/illegal pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module dice_scoreboard #(
  parameter int TARGET    = 30,
  parameter int MAX_ROLLS = 15
) (
  input  wire               clk,
  input  wire               reset_n,
  dice_scoreboard_if.slave  bus
);

  localparam logic [7:0] C_TARGET    = 8'(TARGET);
  localparam logic [4:0] C_MAX_ROLLS = 5'(MAX_ROLLS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_total;
  logic [4:0] r_roll_count;
  logic [2:0] r_last_value;
  logic       r_double_flag;
  logic       r_err_invalid;

  logic       w_ready;
  logic       w_accept;
  logic       w_legal;
  logic [7:0] w_new_total;
  logic [4:0] w_new_count;

  assign w_ready     = (r_state == IDLE) || (r_state == PLAY);
  assign w_accept    = bus.dice_valid && w_ready && !bus.clear;
  assign w_legal     = (bus.dice_value != 3'd0) && (bus.dice_value != 3'd7);
  assign w_new_total = r_total + {5'd0, bus.dice_value};
  assign w_new_count = r_roll_count + 5'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Win is tested before the roll limit so a roll meeting both ends in WON.
  always_comb begin
    w_state_next = r_state;
    if (bus.clear) begin
      w_state_next = IDLE;
    end else if (w_accept && w_legal) begin
      if (w_new_total >= C_TARGET) begin
        w_state_next = WON;
      end else if (w_new_count == C_MAX_ROLLS) begin
        w_state_next = LOST;
      end else begin
        w_state_next = PLAY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_total       <= 8'd0;
      r_roll_count  <= 5'd0;
      r_last_value  <= 3'd0;
      r_double_flag <= 1'b0;
      r_err_invalid <= 1'b0;
    end else begin
      r_double_flag <= 1'b0;
      r_err_invalid <= 1'b0;
      if (bus.clear) begin
        r_total      <= 8'd0;
        r_roll_count <= 5'd0;
        r_last_value <= 3'd0;
      end else if (w_accept) begin
        if (w_legal) begin
          r_total       <= w_new_total;
          r_roll_count  <= w_new_count;
          r_last_value  <= bus.dice_value;
          r_double_flag <= (r_last_value != 3'd0) && (r_last_value == bus.dice_value);
        end else begin
          r_err_invalid <= 1'b1;
        end
      end
    end
  end

  assign bus.dice_ready  = w_ready;
  assign bus.total       = r_total;
  assign bus.roll_count  = r_roll_count;
  assign bus.last_value  = r_last_value;
  assign bus.double_flag = r_double_flag;
  assign bus.err_invalid = r_err_invalid;
  assign bus.game_won    = (r_state == WON);
  assign bus.game_lost   = (r_state == LOST);

endmodule
`default_nettype wire

// File: tb/tb_dice_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_dice_scoreboard
// Description : Scoreboard bench for dice_scoreboard with directed rolls.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_scoreboard;

  typedef struct packed {
    logic [7:0] total;
    logic [4:0] cnt;
    logic [2:0] last;
    logic       dbl;
    logic       err;
    logic       won;
    logic       lost;
    logic       rdy;
  } exp_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  dice_scoreboard_if ifa ();
  dice_scoreboard_if ifb ();

  dice_scoreboard #(.TARGET(30), .MAX_ROLLS(15)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
  dice_scoreboard #(.TARGET(15), .MAX_ROLLS(15)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

  // Second instance sees identical stimulus; only its win/lose outcome differs.
  assign ifb.clear      = ifa.clear;
  assign ifb.dice_valid = ifa.dice_valid;
  assign ifb.dice_value = ifa.dice_value;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t snap_a();
    return '{ifa.total, ifa.roll_count, ifa.last_value, ifa.double_flag,
             ifa.err_invalid, ifa.game_won, ifa.game_lost, ifa.dice_ready};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every edge that presented a roll or clear yields one record.
  always begin
    @(posedge clk);
    if (ifa.dice_valid === 1'b1 || ifa.clear === 1'b1) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL monitor_underflow actual=%h required=none", snap_a());
      end else begin
        check("response", 32'(snap_a()), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic clr, input logic vld, input logic [2:0] v,
                       input logic [7:0] t, input logic [4:0] c, input logic [2:0] l,
                       input logic d, input logic e, input logic w, input logic lo,
                       input logic r);
    @(negedge clk);
    ifa.clear      = clr;
    ifa.dice_valid = vld;
    ifa.dice_value = v;
    exp_q.push_back('{t, c, l, d, e, w, lo, r});
    @(posedge clk);
    #1;
    ifa.clear      = 1'b0;
    ifa.dice_valid = 1'b0;
  endtask

  task automatic roll(input logic [2:0] v, input logic [7:0] t, input logic [4:0] c,
                      input logic [2:0] l, input logic d, input logic e,
                      input logic w, input logic lo, input logic r);
    issue(1'b0, 1'b1, v, t, c, l, d, e, w, lo, r);
  endtask

  task automatic do_clear();
    issue(1'b1, 1'b0, 3'd0, 8'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    ifa.clear = 1'b0;
    ifa.dice_valid = 1'b0;
    ifa.dice_value = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(snap_a()), 32'(exp_t'{8'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    reset_n = 1'b1;

    // Rolls 3,3,5: double on second roll.
    roll(3'd3, 8'd3,  5'd1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd3, 8'd6,  5'd2, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd5, 8'd11, 5'd3, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    @(negedge clk);
    check("double_one_cycle", 32'(ifa.double_flag), 32'd0);
    do_clear();

    // Illegal 0 and 7 stay in IDLE, then 4 is scored.
    roll(3'd0, 8'd0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    roll(3'd7, 8'd0, 5'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    roll(3'd4, 8'd4, 5'd1, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd7, 8'd4, 5'd1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    do_clear();

    // Six 6s: win on the fifth, sixth ignored.
    roll(3'd6, 8'd6,  5'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd6, 8'd12, 5'd2, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd6, 8'd18, 5'd3, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd6, 8'd24, 5'd4, 3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd6, 8'd30, 5'd5, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    roll(3'd6, 8'd30, 5'd5, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    roll(3'd0, 8'd30, 5'd5, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_clear();

    // Fifteen 1s: A (TARGET 30) loses, B (TARGET 15) wins.
    for (int i = 1; i <= 15; i++) begin
      roll(3'd1, 8'(i), 5'(i), 3'd1, (i > 1), 1'b0, 1'b0, (i == 15), (i != 15));
    end
    roll(3'd2, 8'd15, 5'd15, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();
    check("b_won",   32'(ifb.game_won),   32'd1);
    check("b_lost",  32'(ifb.game_lost),  32'd0);
    check("b_total", 32'(ifb.total),      32'd15);
    check("b_count", 32'(ifb.roll_count), 32'd15);
    do_clear();

    // Clear beats a simultaneous roll of 6.
    roll(3'd2, 8'd2, 5'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 1'b1, 3'd6, 8'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd6, 8'd6, 5'd1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    do_clear();

    // Async reset between edges, then a fresh game.
    roll(3'd5, 8'd5, 5'd1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    roll(3'd2, 8'd7, 5'd2, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset", 32'(snap_a()), 32'(exp_t'{8'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}));
    #1 reset_n = 1'b1;
    roll(3'd2, 8'd2, 5'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
